// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-4 Booth multiplier.
//
// Produces one full-width product per WIDTH/2+1 Booth digits plus a single
// DONE cycle. Operands are extended to WIDTH+2 bits. Signed mode uses sign
// extension and unsigned mode uses zero extension, so one signed Booth datapath
// gives the exact product in both modes.
//
// Ports
//   clk_i           clock, all state on rising edge
//   reset_i         synchronous active-low reset
//   start_i         request a multiply (accepted only while ready_o)
//   signed_mode_i   1: two's complement operands, 0: unsigned (captured with start)
//   a_i, b_i        multiplicand / multiplier (captured with start)
//   ready_o         idle, can accept start
//   busy_o          multiply in progress
//   done_o          one-cycle pulse, product_o / overflow_o freshly valid
//   product_o       2*WIDTH-bit product
//   overflow_o      product does not fit in WIDTH bits under the captured mode
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               signed_mode_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o,
    output logic               overflow_o
);
    localparam int N  = WIDTH / 2 + 1;   // Booth digits in a WIDTH+2 bit multiplier
    localparam int CW = $clog2(N + 1);
    localparam int AW = 2 * WIDTH + 4;   // accumulator / partial-product width

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [WIDTH+2:0]   bsh_q,     bsh_d;     // {b_ext, 1'b0}, shifted right 2 per digit
    logic [AW-1:0]      mcand_q,   mcand_d;   // a_ext sign-extended, shifted left 2 per digit
    logic [AW-1:0]      acc_q,     acc_d;
    logic               mode_q,    mode_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               ovf_q,     ovf_d;

    logic               a_sx, b_sx;
    logic [AW-1:0]      pp;
    logic [AW-1:0]      acc_nxt;
    logic [2*WIDTH-1:0] prod_nxt;
    logic               ovf_nxt;
    logic               last_digit;

    // Extension bit: the operand's MSB in signed mode, zero otherwise.
    assign a_sx = signed_mode_i & a_i[WIDTH-1];
    assign b_sx = signed_mode_i & b_i[WIDTH-1];

    // Low triplet of the shift register is {b[2k+1], b[2k], b[2k-1]} for digit k.
    always_comb begin
        pp = '0;
        case (bsh_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = {mcand_q[AW-2:0], 1'b0};
            3'b100:         pp = ~{mcand_q[AW-2:0], 1'b0} + 1'b1;
            3'b101, 3'b110: pp = ~mcand_q + 1'b1;
            default:        pp = '0;
        endcase
    end

    assign acc_nxt    = acc_q + pp;
    assign prod_nxt   = acc_nxt[2*WIDTH-1:0];
    assign last_digit = (cnt_q == CW'(N - 1));

    // Signed: upper WIDTH+1 bits must be a pure sign extension.
    // Unsigned: upper WIDTH bits must be zero.
    assign ovf_nxt = mode_q ? !((&prod_nxt[2*WIDTH-1:WIDTH-1]) || !(|prod_nxt[2*WIDTH-1:WIDTH-1]))
                            : (|prod_nxt[2*WIDTH-1:WIDTH]);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bsh_d     = bsh_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mode_d    = mode_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    acc_d   = '0;
                    mode_d  = signed_mode_i;
                    mcand_d = {{(AW-WIDTH){a_sx}}, a_i};
                    bsh_d   = {{2{b_sx}}, b_i, 1'b0};
                end
            end
            S_CALC: begin
                acc_d   = acc_nxt;
                cnt_d   = cnt_q + 1'b1;
                bsh_d   = {2'b00, bsh_q[WIDTH+2:2]};
                mcand_d = {mcand_q[AW-3:0], 2'b00};
                if (last_digit) begin
                    state_d   = S_DONE;
                    product_d = prod_nxt;
                    ovf_d     = ovf_nxt;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bsh_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            mode_q    <= 1'b0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bsh_q     <= bsh_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mode_q    <= mode_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ready_o    = (state_q == S_IDLE);
    assign busy_o     = (state_q == S_CALC);
    assign done_o     = (state_q == S_DONE);
    assign product_o  = product_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: a WIDTH=32 and a WIDTH=8 instance on one clock.
module tb_booth_mult_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        sm;
    logic        start32, start8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        ready32, busy32, done32, ovf32;
    logic        ready8, busy8, done8, ovf8;
    logic [63:0] prod32;
    logic [15:0] prod8;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          w8;
        bit          sm;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        bit          ovf;
    } vec_t;

    typedef struct {
        logic [63:0] p;
        bit          ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(32)) dut32 (
        .clk_i(clk), .reset_i(reset_n), .start_i(start32), .signed_mode_i(sm),
        .a_i(a32), .b_i(b32), .ready_o(ready32), .busy_o(busy32), .done_o(done32),
        .product_o(prod32), .overflow_o(ovf32)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk_i(clk), .reset_i(reset_n), .start_i(start8), .signed_mode_i(sm),
        .a_i(a8), .b_i(b8), .ready_o(ready8), .busy_o(busy8), .done_o(done8),
        .product_o(prod8), .overflow_o(ovf8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference arithmetic, independent of the Booth datapath.
    function automatic void model(input bit w8, input bit msm, input logic [31:0] a,
                                  input logic [31:0] b, output logic [63:0] p, output bit ovf);
        logic signed [63:0] sa, sb, sp;
        logic [15:0] q;
        if (!w8) begin
            sa  = msm ? {{32{a[31]}}, a} : {32'b0, a};
            sb  = msm ? {{32{b[31]}}, b} : {32'b0, b};
            sp  = sa * sb;
            p   = sp;
            ovf = msm ? !((&p[63:31]) || !(|p[63:31])) : (|p[63:32]);
        end else begin
            sa  = msm ? {{56{a[7]}}, a[7:0]} : {56'b0, a[7:0]};
            sb  = msm ? {{56{b[7]}}, b[7:0]} : {56'b0, b[7:0]};
            sp  = sa * sb;
            q   = sp[15:0];
            p   = {48'b0, q};
            ovf = msm ? !((&q[15:7]) || !(|q[15:7])) : (|q[15:8]);
        end
    endfunction

    // Start one multiply from a negedge, follow it to completion. With poke set,
    // stray starts are pulsed in cycle 4 (CALC) and in the DONE cycle.
    task automatic run_vec(input bit w8, input bit vsm, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] p, input bit vovf,
                           input bit poke);
        int   n;
        int   done_cyc;
        bit   busy_ok;
        bit   bsy, dn, rdy, ov;
        logic [63:0] pr;
        exp_t e;
        n        = w8 ? 5 : 17;
        done_cyc = -1;
        busy_ok  = 1'b1;
        e        = '{p, vovf};
        sbq.push_back('{p, vovf});
        @(negedge clk);
        sm = vsm;
        if (w8) begin a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; end
        else    begin a32 = a;     b32 = b;     start32 = 1'b1; end
        @(negedge clk);
        start8 = 1'b0; start32 = 1'b0;
        for (int cyc = 1; cyc <= n + 6 && done_cyc < 0; cyc++) begin
            if (cyc > 1) @(negedge clk);
            bsy = w8 ? busy8 : busy32;
            dn  = w8 ? done8 : done32;
            pr  = w8 ? {48'b0, prod8} : prod32;
            ov  = w8 ? ovf8 : ovf32;
            if (bsy != (cyc <= n)) busy_ok = 1'b0;
            if (cyc == 2) begin
                // operand and mode changes while busy must not matter
                a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
                sm = ~sm;
            end
            if (poke && cyc == 4) begin
                a32 = 32'd7; b32 = 32'd7; start32 = 1'b1;
            end
            if (poke && cyc == 5) start32 = 1'b0;
            if (dn) begin
                done_cyc = cyc;
                if (sbq.size() > 0) e = sbq.pop_front();
                chk("product", pr, e.p);
                chk("overflow", 64'(ov), 64'(e.ovf));
                if (poke) start32 = 1'b1;
            end
        end
        if (done_cyc < 0 && sbq.size() > 0) void'(sbq.pop_front());
        chk("done_cycle", 64'(done_cyc), 64'(n + 1));
        chk("busy_window", 64'(busy_ok), 64'd1);
        @(negedge clk);
        start32 = 1'b0;
        rdy = w8 ? ready8 : ready32;
        pr  = w8 ? {48'b0, prod8} : prod32;
        chk("ready_after", 64'(rdy), 64'd1);
        chk("product_hold", pr, e.p);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] mp;
        bit          mo;
        logic [31:0] ra, rb;
        bit          no_done;

        reset_n = 1'b0; start32 = 1'b0; start8 = 1'b0; sm = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;

        vecs.push_back('{0, 1, 32'hFFFFFFFE, 32'd2,        64'hFFFF_FFFF_FFFF_FFFC, 0});
        vecs.push_back('{0, 0, 32'd25,       32'd39,       64'h0000_0000_0000_03CF, 0});
        vecs.push_back('{0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFF_FFFE_0000_0001, 1});
        vecs.push_back('{0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000_0000_0000_0001, 0});
        vecs.push_back('{0, 1, 32'h80000000, 32'h80000000, 64'h4000_0000_0000_0000, 1});
        vecs.push_back('{0, 0, 32'h80000000, 32'h80000000, 64'h4000_0000_0000_0000, 1});
        vecs.push_back('{0, 1, 32'd7,        32'hFFFFFFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0});
        vecs.push_back('{0, 1, 32'h00010000, 32'h00008000, 64'h0000_0000_8000_0000, 1});
        vecs.push_back('{1, 1, 32'h80,       32'h7F,       64'h0000_0000_0000_C080, 1});
        vecs.push_back('{1, 0, 32'hFF,       32'hFF,       64'h0000_0000_0000_FE01, 1});
        vecs.push_back('{1, 1, 32'h80,       32'h80,       64'h0000_0000_0000_4000, 1});
        vecs.push_back('{1, 1, 32'hFF,       32'hFF,       64'h0000_0000_0000_0001, 0});
        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom;
            model(1'b0, i[0], ra, rb, mp, mo);
            vecs.push_back('{0, i[0], ra, rb, mp, mo});
            model(1'b1, i[0], ra, rb, mp, mo);
            vecs.push_back('{1, i[0], ra, rb, mp, mo});
        end

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("reset_ready32", 64'({ready32, busy32, done32, ovf32}), 64'b1000);
        chk("reset_prod32", prod32, 64'd0);
        chk("reset_state8", {47'b0, ready8, busy8, done8, ovf8, prod8}, {47'b0, 4'b1000, 16'h0});

        foreach (vecs[i])
            run_vec(vecs[i].w8, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].ovf, 1'b0);

        // Stray starts during CALC and DONE are ignored.
        run_vec(1'b0, 1'b0, 32'd3, 32'd5, 64'd15, 1'b0, 1'b1);

        // Abort mid-CALC; reset coincides with a start request.
        no_done = 1'b1;
        @(negedge clk);
        sm = 1'b0; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (done32) no_done = 1'b0;
            if (cyc == 4) begin a32 = 32'd7; b32 = 32'd7; start32 = 1'b1; end
            if (cyc == 5) start32 = 1'b0;
            if (cyc == 6) begin reset_n = 1'b0; start32 = 1'b1; end
        end
        @(negedge clk);
        if (done32) no_done = 1'b0;
        chk("abort_state", 64'({ready32, busy32, done32, ovf32}), 64'b1000);
        chk("abort_prod", prod32, 64'd0);
        reset_n = 1'b1; start32 = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done32) no_done = 1'b0;
        end
        chk("abort_no_done", 64'(no_done), 64'd1);
        run_vec(1'b0, 1'b0, 32'd6, 32'd7, 64'd42, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
